// File: rtl/pindriver_bus.sv
// Registered output driver for a bidirectional pin bus: sequences output-enable through
// setup, drive, hold and turnaround phases, all timed by the shared 'ena' tick.
module pindriver_bus #(
   parameter int WIDTH       = 8,
   parameter int SETUP_TICKS = 1,
   parameter int HOLD_TICKS  = 2,
   parameter int TURN_TICKS  = 1,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ena,
   input  logic             req,
   input  logic [WIDTH-1:0] din,
   output logic             ack,
   input  logic             phase_end,
   input  logic             abort,
   output logic [WIDTH-1:0] pin_d,
   output logic             pin_oe,
   output logic             drv_valid,
   output logic             busy
);

   typedef enum logic [2:0] {IDLE, SETUP, DRIVE, HOLD, TURN} state_t;

   localparam logic [CNT_W-1:0] SETUP_CNT = CNT_W'(SETUP_TICKS);
   localparam logic [CNT_W-1:0] HOLD_CNT  = CNT_W'(HOLD_TICKS);
   localparam logic [CNT_W-1:0] TURN_CNT  = CNT_W'(TURN_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             pend, pend_n;
   logic [WIDTH-1:0] d_n;
   logic             oe_n, ack_n;
   logic             go_hold, go_turn;
   logic             last_tick;

   // A phase ends on the tick that takes the counter to zero, so it lasts exactly *_TICKS ticks.
   assign last_tick = (cnt <= CNT_ONE);

   // NOTE: every output is a flop fed from next-state logic, and sequential state uses
   // non-blocking assignments so all registers update together from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         pend      <= 1'b0;
         pin_d     <= '1;
         pin_oe    <= 1'b0;
         ack       <= 1'b0;
         drv_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         pend      <= pend_n;
         pin_d     <= d_n;
         pin_oe    <= oe_n;
         ack       <= ack_n;
         drv_valid <= (state_n == DRIVE);
         busy      <= (state_n != IDLE);
      end
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pend_n  = pend;
      d_n     = pin_d;
      oe_n    = pin_oe;
      ack_n   = 1'b0;
      go_hold = 1'b0;
      go_turn = 1'b0;

      if (abort) begin
         if (state != IDLE) begin
            oe_n   = 1'b0;
            d_n    = '1;
            pend_n = 1'b0;
            if (TURN_TICKS > 0) begin
               state_n = TURN;
               cnt_n   = TURN_CNT;
            end else begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (req) begin
                  d_n   = din;
                  oe_n  = 1'b1;
                  ack_n = 1'b1;
                  if (SETUP_TICKS > 0) begin
                     state_n = SETUP;
                     cnt_n   = SETUP_CNT;
                  end else begin
                     state_n = DRIVE;
                     cnt_n   = '0;
                  end
               end
            end
            SETUP: begin
               if (phase_end) pend_n = 1'b1;
               if (last_tick) begin
                  pend_n = 1'b0;
                  // A host strobe that already ended during setup skips the drive phase.
                  if (pend || phase_end) begin
                     go_hold = 1'b1;
                  end else begin
                     state_n = DRIVE;
                     cnt_n   = '0;
                  end
               end else begin
                  cnt_n = cnt - CNT_ONE;
               end
            end
            DRIVE: begin
               if (phase_end) go_hold = 1'b1;
            end
            HOLD: begin
               if (last_tick) go_turn = 1'b1;
               else           cnt_n   = cnt - CNT_ONE;
            end
            TURN: begin
               if (last_tick) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt - CNT_ONE;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase

         if (go_hold) begin
            if (HOLD_TICKS > 0) begin
               state_n = HOLD;
               cnt_n   = HOLD_CNT;
            end else begin
               go_turn = 1'b1;
            end
         end

         if (go_turn) begin
            oe_n = 1'b0;
            d_n  = '1;
            if (TURN_TICKS > 0) begin
               state_n = TURN;
               cnt_n   = TURN_CNT;
            end else begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pindriver_bus.sv
// Bench for pindriver_bus: three configurations (defaults, long setup, all-zero ticks),
// with accepted data tracked by a scoreboard and phase lengths measured in clocks.
module tb_pindriver_bus;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic       ena     = 1'b1;
   logic [7:0] din     = 8'h00;
   logic [2:0] req       = '0;
   logic [2:0] phase_end = '0;
   logic [2:0] abort     = '0;
   logic [2:0] ack, pin_oe, drv_valid, busy;
   logic [7:0] pin_d [3];

   typedef struct {
      int         idx;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp_e;
   int   n_err = 0;
   int   n_chk = 0;
   int   ack_cnt [3] = '{0, 0, 0};
   int   drv_cnt [3] = '{0, 0, 0};
   int   ena_edges = 0;
   int   ena_mode  = 0;
   int   ena_ph    = 0;
   bit   chk_align = 1'b0;
   logic ena_q     = 1'b1;
   logic       prev_oe = 1'b0;
   logic [7:0] prev_d  = 8'hFF;

   always #5 clk = ~clk;

   pindriver_bus u_def (
      .clk(clk), .reset_n(reset_n), .ena(ena), .req(req[0]), .din(din), .ack(ack[0]),
      .phase_end(phase_end[0]), .abort(abort[0]), .pin_d(pin_d[0]), .pin_oe(pin_oe[0]),
      .drv_valid(drv_valid[0]), .busy(busy[0]));

   pindriver_bus #(.SETUP_TICKS(3)) u_s3 (
      .clk(clk), .reset_n(reset_n), .ena(ena), .req(req[1]), .din(din), .ack(ack[1]),
      .phase_end(phase_end[1]), .abort(abort[1]), .pin_d(pin_d[1]), .pin_oe(pin_oe[1]),
      .drv_valid(drv_valid[1]), .busy(busy[1]));

   pindriver_bus #(.SETUP_TICKS(0), .HOLD_TICKS(0), .TURN_TICKS(0)) u_z (
      .clk(clk), .reset_n(reset_n), .ena(ena), .req(req[2]), .din(din), .ack(ack[2]),
      .phase_end(phase_end[2]), .abort(abort[2]), .pin_d(pin_d[2]), .pin_oe(pin_oe[2]),
      .drv_valid(drv_valid[2]), .busy(busy[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ena generator: 0 = every clk, 1 = every 4th clk, 2 = held low.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ena_mode)
            0: ena = 1'b1;
            1: begin
               ena_ph = (ena_ph + 1) % 4;
               ena    = (ena_ph == 0);
            end
            default: ena = 1'b0;
         endcase
      end
   end

   always @(posedge clk) begin
      ena_q <= ena;
      if (ena) ena_edges <= ena_edges + 1;
   end

   // Scoreboard: every ack pops the value pushed when that request was driven.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (drv_valid[i]) drv_cnt[i] <= drv_cnt[i] + 1;
         if (ack[i]) begin
            ack_cnt[i] <= ack_cnt[i] + 1;
            if (exp_q.size() == 0) begin
               check("sb_unexpected_ack", 32'(i), 32'hFFFF_FFFF);
            end else begin
               exp_e = exp_q.pop_front();
               check("sb_idx", 32'(i), 32'(exp_e.idx));
               check("sb_data", 32'(pin_d[i]), 32'(exp_e.data));
               check("sb_oe", 32'(pin_oe[i]), 32'd1);
            end
         end
      end
      if (chk_align && (pin_oe[0] !== prev_oe || pin_d[0] !== prev_d))
         check("pin_change_on_ena", 32'(ena_q), 32'd1);
      prev_oe <= pin_oe[0];
      prev_d  <= pin_d[0];
   end

   task automatic wait_ack(input int idx);
      int t = 0;
      while (!ack[idx] && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("ack_seen", 32'(ack[idx]), 32'd1);
   endtask

   task automatic start_txn(input int idx, input logic [7:0] data);
      int t = 0;
      @(negedge clk);
      din      = data;
      req[idx] = 1'b1;
      exp_q.push_back('{idx, data});
      wait_ack(idx);
      req[idx] = 1'b0;
      while (!drv_valid[idx] && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("drv_up", 32'(drv_valid[idx]), 32'd1);
   endtask

   task automatic finish_txn(input int idx);
      int t = 0;
      while (busy[idx] && t < 400) begin
         if (drv_valid[idx]) phase_end[idx] = 1'b1;
         @(negedge clk);
         t++;
      end
      phase_end[idx] = 1'b0;
      check("back_to_idle", 32'(busy[idx]), 32'd0);
   endtask

   // Full transaction with phase lengths in clocks: setup/hold/turn ticks scaled by k.
   task automatic run_txn(input int idx, input logic [7:0] data, input int k,
                          input int s, input int h, input int tt);
      int   t;
      logic d0;
      @(negedge clk);
      din      = data;
      req[idx] = 1'b1;
      exp_q.push_back('{idx, data});
      wait_ack(idx);
      d0       = drv_valid[idx];
      req[idx] = 1'b0;
      @(negedge clk);
      check("ack_one_clk", 32'(ack[idx]), 32'd0);
      if (d0) begin
         t = 0;
      end else begin
         t = 1;
         while (!drv_valid[idx] && t < 400) begin
            @(negedge clk);
            t++;
         end
      end
      check("setup_len", 32'(t), 32'(s * k));
      check("drive_oe", 32'(pin_oe[idx]), 32'd1);
      check("drive_d", 32'(pin_d[idx]), 32'(data));
      phase_end[idx] = 1'b1;
      t = 0;
      while (drv_valid[idx] && t < 400) begin
         @(negedge clk);
         t++;
      end
      phase_end[idx] = 1'b0;
      check("drv_drop", 32'(drv_valid[idx]), 32'd0);
      t = 0;
      while (pin_oe[idx] && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("hold_len", 32'(t), 32'(h * k));
      check("release_d", 32'(pin_d[idx]), 32'hFF);
      t = 0;
      while (busy[idx] && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("turn_len", 32'(t), 32'(tt * k));
   endtask

   task automatic reset_mid(input int idx, input logic [7:0] data);
      start_txn(idx, data);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_oe", 32'(pin_oe[idx]), 32'd0);
      check("rst_mid_d", 32'(pin_d[idx]), 32'hFF);
      check("rst_mid_drv", 32'(drv_valid[idx]), 32'd0);
      check("rst_mid_ack", 32'(ack[idx]), 32'd0);
      check("rst_mid_busy", 32'(busy[idx]), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_after_busy", 32'(busy[idx]), 32'd0);
      check("rst_after_oe", 32'(pin_oe[idx]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int t;
      int mark;
      int a0;
      int d0;

      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("reset_oe", 32'(pin_oe[i]), 32'd0);
         check("reset_d", 32'(pin_d[i]), 32'hFF);
         check("reset_busy", 32'(busy[i]), 32'd0);
         check("reset_drv", 32'(drv_valid[i]), 32'd0);
         check("reset_ack", 32'(ack[i]), 32'd0);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Default timing, then all-zero ticks.
      run_txn(0, 8'hA5, 1, 1, 2, 1);
      run_txn(2, 8'h5C, 1, 0, 0, 0);

      // ena every 4th clk: durations scale by four, pins move only on ena edges.
      ena_mode  = 1;
      repeat (2) @(negedge clk);
      chk_align = 1'b1;
      run_txn(0, 8'h3B, 4, 1, 2, 1);
      chk_align = 1'b0;
      ena_mode  = 0;
      repeat (2) @(negedge clk);

      // phase_end during a 3-tick setup: no drive phase, hold starts at setup expiry.
      d0 = drv_cnt[1];
      @(negedge clk);
      din    = 8'h5A;
      req[1] = 1'b1;
      exp_q.push_back('{1, 8'h5A});
      wait_ack(1);
      req[1]       = 1'b0;
      phase_end[1] = 1'b1;
      @(negedge clk);
      phase_end[1] = 1'b0;
      t = 1;
      while (pin_oe[1] && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("s3_oe_len", 32'(t), 32'd5);
      check("s3_release_d", 32'(pin_d[1]), 32'hFF);
      t = 0;
      while (busy[1] && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("s3_turn_len", 32'(t), 32'd1);
      check("s3_no_drv_valid", 32'(drv_cnt[1] - d0), 32'd0);

      // abort in DRIVE with ena low, then a new request waits out the turnaround.
      start_txn(0, 8'h69);
      ena_mode = 2;
      repeat (2) @(negedge clk);
      mark     = ena_edges;
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      check("abort_oe", 32'(pin_oe[0]), 32'd0);
      check("abort_d", 32'(pin_d[0]), 32'hFF);
      check("abort_drv", 32'(drv_valid[0]), 32'd0);
      check("abort_busy", 32'(busy[0]), 32'd1);
      a0     = ack_cnt[0];
      din    = 8'h77;
      req[0] = 1'b1;
      exp_q.push_back('{0, 8'h77});
      repeat (4) @(negedge clk);
      check("abort_no_ack_frozen", 32'(ack_cnt[0] - a0), 32'd0);
      ena_mode = 0;
      wait_ack(0);
      req[0] = 1'b0;
      check("abort_turn_ticks", 32'(ena_edges - mark), 32'd2);
      finish_txn(0);

      // abort and phase_end together in DRIVE: abort wins.
      start_txn(0, 8'h24);
      abort[0]     = 1'b1;
      phase_end[0] = 1'b1;
      @(negedge clk);
      abort[0]     = 1'b0;
      phase_end[0] = 1'b0;
      check("abort_pe_oe", 32'(pin_oe[0]), 32'd0);
      check("abort_pe_busy", 32'(busy[0]), 32'd1);
      finish_txn(0);

      // req and abort together in IDLE: no ack until abort drops.
      @(negedge clk);
      din      = 8'hE1;
      req[0]   = 1'b1;
      abort[0] = 1'b1;
      @(negedge clk);
      check("req_abort_no_ack", 32'(ack[0]), 32'd0);
      check("req_abort_idle", 32'(busy[0]), 32'd0);
      exp_q.push_back('{0, 8'hE1});
      abort[0] = 1'b0;
      wait_ack(0);
      req[0] = 1'b0;
      finish_txn(0);

      // req held through hold/turn: second ack only from IDLE, with din of that moment.
      @(negedge clk);
      din    = 8'hC3;
      req[0] = 1'b1;
      exp_q.push_back('{0, 8'hC3});
      wait_ack(0);
      din = 8'h11;
      t   = 0;
      while (!drv_valid[0] && t < 400) begin
         @(negedge clk);
         t++;
      end
      phase_end[0] = 1'b1;
      t = 0;
      while (drv_valid[0] && t < 400) begin
         @(negedge clk);
         t++;
      end
      phase_end[0] = 1'b0;
      a0 = ack_cnt[0];
      t  = 0;
      while (pin_oe[0] && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("held_req_no_early_ack", 32'(ack_cnt[0] - a0), 32'd0);
      din = 8'h3C;
      exp_q.push_back('{0, 8'h3C});
      t = 0;
      while (!ack[0] && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("held_req_ack_latency", 32'(t), 32'd2);
      req[0] = 1'b0;
      finish_txn(0);

      // Asynchronous reset mid-drive, for defaults and all-zero ticks.
      reset_mid(0, 8'h96);
      reset_mid(2, 8'h4B);
      run_txn(0, 8'h0F, 1, 1, 2, 1);
      run_txn(2, 8'hF0, 1, 0, 0, 0);

      repeat (2) @(negedge clk);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
